// File: rtl/alu_cmd_pkg.sv
// Shared types and default widths for the ALU command queue.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package alu_cmd_pkg;

  localparam int DW_DEF      = 8;
  localparam int OPW_DEF     = 3;
  localparam int RW_DEF      = 16;
  localparam int DEPTH_DEF   = 4;
  localparam int TIMEOUT_DEF = 16;

  // One queued ALU command at the default operand/opcode widths
  typedef struct packed {
    logic [DW_DEF-1:0]  a;
    logic [DW_DEF-1:0]  b;
    logic [OPW_DEF-1:0] op;
  } cmd_t;

  // Issue sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/alu_cmd_queue_if.sv
// Bundle of command, ALU-side and response signals of the command queue.
// Latency: none (wiring only).
// Backpressure: cmd_ready/cmd_valid upstream, rsp_valid/rsp_ready downstream.
interface alu_cmd_queue_if
  import alu_cmd_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int OPW   = OPW_DEF,
  parameter int RW    = RW_DEF,
  parameter int DEPTH = DEPTH_DEF
) ();

  localparam int CW = $clog2(DEPTH) + 1;

  logic           cmd_valid;
  logic           cmd_ready;
  logic [DW-1:0]  cmd_a;
  logic [DW-1:0]  cmd_b;
  logic [OPW-1:0] cmd_op;
  logic [DW-1:0]  A;
  logic [DW-1:0]  B;
  logic [OPW-1:0] op;
  logic           start;
  logic [RW-1:0]  result;
  logic           done;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [RW-1:0]  rsp_result;
  logic [OPW-1:0] rsp_op;
  logic           rsp_err;
  logic [CW-1:0]  count;

  // Queue side
  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, result, done, rsp_ready,
    output cmd_ready, A, B, op, start, rsp_valid, rsp_result, rsp_op, rsp_err, count
  );

  // Environment side (producer, ALU and consumer)
  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, result, done, rsp_ready,
    input  cmd_ready, A, B, op, start, rsp_valid, rsp_result, rsp_op, rsp_err, count
  );

endinterface

// File: rtl/alu_cmd_fifo.sv
// Power-of-two circular command FIFO with occupancy count.
// Latency: head visible combinationally; a push shows up at the head the cycle after.
// Backpressure: push ignored while full, pop ignored while empty.
module alu_cmd_fifo
  import alu_cmd_pkg::*;
#(
  parameter int  DEPTH = DEPTH_DEF,
  parameter type T     = cmd_t
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  T                       din,
  input  logic                   pop,
  output T                       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  T               r_mem [DEPTH];
  logic [AW-1:0]  r_wptr;
  logic [AW-1:0]  r_rptr;
  logic [AW:0]    r_count;
  logic           w_do_push;
  logic           w_do_pop;

  assign full      = (r_count == (AW+1)'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign dout      = r_mem[r_rptr];
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  // Pointers wrap naturally at DEPTH; count only moves on an unbalanced push/pop
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + AW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read after being written
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= din;
  end

endmodule

// File: rtl/alu_cmd_queue.sv
// Queues ALU commands and issues them one at a time, returning result or timeout.
// Latency: start 2 edges after accept into an idle empty queue; response 1 cycle after done.
// Backpressure: cmd_ready drops when queue full; response held until rsp_ready.
module alu_cmd_queue
  import alu_cmd_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int OPW     = OPW_DEF,
  parameter int RW      = RW_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic           clk,
  input  logic           reset_n,
  alu_cmd_queue_if.slave bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  // Same layout as cmd_t, sized to this instance's operand/opcode widths
  typedef struct packed {
    logic [DW-1:0]  a;
    logic [DW-1:0]  b;
    logic [OPW-1:0] op;
  } cmd_w_t;

  cmd_w_t         w_push_dat;
  cmd_w_t         w_head_dat;
  logic           w_full;
  logic           w_empty;
  logic           w_push;
  logic           w_pop;
  logic [CW-1:0]  w_count;
  logic [RW-1:0]  w_result;
  state_t         r_state;
  logic [TW-1:0]  r_wait_cnt;

  assign w_push_dat    = '{a: bus.cmd_a, b: bus.cmd_b, op: bus.cmd_op};
  assign w_push        = bus.cmd_valid && !w_full;
  assign w_pop         = (r_state == IDLE) && !w_empty && !bus.rsp_valid;
  assign w_result      = bus.result;
  assign bus.cmd_ready = !w_full;
  assign bus.count     = w_count;

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .T     (cmd_w_t)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (w_push),
    .din     (w_push_dat),
    .pop     (w_pop),
    .dout    (w_head_dat),
    .full    (w_full),
    .empty   (w_empty),
    .count   (w_count)
  );

  // Issue sequencer: one command in flight, all ALU and response outputs registered
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= IDLE;
      r_wait_cnt     <= '0;
      bus.start      <= 1'b0;
      bus.A          <= '0;
      bus.B          <= '0;
      bus.op         <= '0;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_result <= '0;
      bus.rsp_op     <= '0;
      bus.rsp_err    <= 1'b0;
    end else begin
      bus.start <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            bus.A     <= w_head_dat.a;
            bus.B     <= w_head_dat.b;
            bus.op    <= w_head_dat.op;
            bus.start <= 1'b1;
            r_state   <= ISSUE;
          end
        end
        ISSUE: begin
          r_wait_cnt <= '0;
          r_state    <= WAIT;
        end
        WAIT: begin
          if (bus.done) begin
            bus.rsp_result <= w_result;
            bus.rsp_op     <= bus.op;
            bus.rsp_err    <= 1'b0;
            bus.rsp_valid  <= 1'b1;
            r_state        <= RESP;
          end else if (r_wait_cnt == TW'(TIMEOUT - 1)) begin
            // This edge is the TIMEOUT-th one waited without done
            bus.rsp_result <= '0;
            bus.rsp_op     <= bus.op;
            bus.rsp_err    <= 1'b1;
            bus.rsp_valid  <= 1'b1;
            r_state        <= RESP;
          end else begin
            r_wait_cnt <= r_wait_cnt + TW'(1);
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            r_state       <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_cmd_queue.md
ALU_CMD_QUEUE -- requirements
Module: alu_cmd_queue

Interface
REQ-001 SHALL have parameter DW, default 8, ALU operand width.
REQ-002 SHALL have parameter OPW, default 3, ALU opcode width.
REQ-003 SHALL have parameter RW, default 16, ALU result width.
REQ-004 SHALL have parameter DEPTH, default 4 (power of two, >=2), command queue depth.
REQ-005 SHALL have parameter TIMEOUT, default 16, max cycles waited for done.
REQ-006 clk  input  1  single clock, all state on rising edge.
REQ-007 reset_n  input  1  asynchronous, active-low reset.
REQ-008 cmd_valid  input  1  upstream command present.
REQ-009 cmd_ready  output  1  queue can accept (= not full).
REQ-010 cmd_a, cmd_b  input  DW  command operands.
REQ-011 cmd_op  input  OPW  command opcode.
REQ-012 A, B  output  DW  operands driven to ALU.
REQ-013 op  output  OPW  opcode driven to ALU.
REQ-014 start  output  1  one-cycle ALU start pulse.
REQ-015 result  input  RW  ALU result, valid when done=1.
REQ-016 done  input  1  ALU completion.
REQ-017 rsp_valid  output  1  response held for downstream.
REQ-018 rsp_ready  input  1  downstream accepts response.
REQ-019 rsp_result  output  RW  captured result (0 on timeout).
REQ-020 rsp_op  output  OPW  opcode of the completed command.
REQ-021 rsp_err  output  1  response is a timeout.
REQ-022 count  output  $clog2(DEPTH)+1  queued command count (excludes in-flight).

Function
REQ-023 Command accepted on rising edge with cmd_valid && cmd_ready; push while full SHALL be impossible (cmd_ready=0), even if a pop occurs that cycle.
REQ-024 Queue SHALL be FIFO order; pointers wrap modulo DEPTH; simultaneous push and pop when not full/empty leaves count unchanged.
REQ-025 FSM states IDLE, ISSUE, WAIT, RESP.
REQ-026 IDLE -> ISSUE when count>0 and rsp_valid=0; head popped on this edge into A/B/op registers.
REQ-027 ISSUE: start=1 exactly this one cycle; -> WAIT unconditionally.
REQ-028 WAIT: A/B/op held stable; cycle counter increments; done=1 -> capture result, rsp_op=op, rsp_err=0 -> RESP.
REQ-029 WAIT: counter reaching TIMEOUT without done -> rsp_result=0, rsp_err=1 -> RESP.
REQ-030 RESP: rsp_valid=1, outputs stable until rsp_valid && rsp_ready edge -> IDLE.
REQ-031 done SHALL be ignored in IDLE, ISSUE and RESP.
REQ-032 Latency: command pushed into empty queue with FSM IDLE -> start high 2 cycles after accept edge; rsp_valid high the cycle after done sampled.
REQ-033 Only one command in flight; back-to-back issue minimum 4 cycles apart (ISSUE, WAIT>=1, RESP, IDLE).

Reset
REQ-034 reset_n low SHALL immediately clear queue (count=0), FSM to IDLE, start=0, rsp_valid=0, rsp_err=0, A=B=op=0, rsp_result=0, rsp_op=0, cmd_ready=1.
REQ-035 Reset mid-WAIT SHALL discard in-flight and queued commands with no response; a later done SHALL be ignored.

Structure
REQ-036 Package alu_cmd_pkg SHALL hold cmd_t struct {a, b, op}, the FSM state enum and default width constants.
REQ-037 Queue storage SHALL be a sub-module alu_cmd_fifo (parameterised on DEPTH, element type cmd_t).

Verification
REQ-038 Single cmd a=8'h05 b=8'h03 op=3'd0, ALU done 3 cycles after start with result 16'h0008 -> one start pulse, A=05 B=03, rsp_result=0008, rsp_err=0.
REQ-039 Push 5 cmds with rsp_ready=0 and done prompt -> first issued, 4 queued, cmd_ready=0 at count=4; releasing rsp_ready drains all in order.
REQ-040 TIMEOUT=16, done never asserted -> rsp_valid with rsp_err=1, rsp_result=0000, 17 cycles after start; next command then issues normally.
REQ-041 done pulsed while IDLE and in RESP -> no response change, no spurious rsp_valid.
REQ-042 reset_n low during WAIT with 2 queued -> count=0, start=0, rsp_valid=0 asynchronously; subsequent done ignored.
REQ-043 Full queue with simultaneous cmd_valid=1 and pop -> push rejected, count 4->3.
